data_memory_param: RTL
======================

Name: data_memory_param

Overview:
Parametrised successor of the single-port-style data memory: one write port and one read port on a single clock, with byte-lane write strobes, 1-cycle registered read with valid flag, same-cycle write-to-read forwarding, and out-of-range address detection. After reset it runs a self-clearing sweep that zeroes every word before accepting traffic. It sits in the datapath's MEM stage and is driven by the load/store unit.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8
DEPTH, 64, number of words; power of two not required, >= 2
ADDR_W, 32, width of address ports; word-indexed, not byte-indexed

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
MemWrite  in  1  write request
MemRead  in  1  read request
write_address  in  ADDR_W  word index for write
read_address  in  ADDR_W  word index for read
Write_data  in  DATA_W  write data
byte_en  in  DATA_W/8  per-byte write strobe; bit i covers bits [8i+7:8i]
MemData_out  out  DATA_W  registered read data
read_valid  out  1  MemData_out updated this cycle
busy  out  1  clear sweep in progress; requests ignored
addr_err  out  1  1-cycle pulse: previous-cycle request had address >= DEPTH
parity_err  out  1  only with DM_PARITY_EN (see below)
perr_inject  in  1  only with DM_PARITY_EN

Behaviour:
- Reset sampled at posedge clk; reset low -> MemData_out=0, read_valid=0, addr_err=0, busy=1, FSM=CLEAR, clear index=0.
- FSM CLEAR: each cycle with reset high, mem[index]<=0, index++; when index==DEPTH-1, that word is cleared and FSM->READY next edge. busy=1 throughout CLEAR, so busy drops exactly DEPTH cycles after reset deasserts. Reset low mid-sweep restarts at index 0.
- While busy: MemWrite/MemRead ignored, read_valid=0, addr_err=0, MemData_out holds 0.
- READY write: MemWrite=1 and write_address<DEPTH -> at the edge, mem[addr] byte i <= Write_data byte i for every set byte_en[i]; other bytes unchanged. byte_en=0 is a legal no-op.
- READY read: MemRead=1 -> next cycle read_valid=1, MemData_out=mem[read_address]. MemRead=0 -> read_valid=0, MemData_out holds last value.
- Forwarding: same-cycle write and read to the same in-range address returns the post-write word (enabled bytes from Write_data, remaining bytes from memory).
- Out of range (address >= DEPTH, full ADDR_W compared): write dropped; read returns MemData_out=0 with read_valid=1. addr_err=1 the following cycle if either port was out of range with its request asserted.
- Address comparison uses the full port width; no wrap-around or truncation.

Optional Feature:
DM_PARITY_EN defined: one even-parity bit is stored per byte, computed on write for every enabled byte. perr_inject=1 during a write stores the inverted parity for the enabled bytes. On a read, parity is checked on all bytes; parity_err=1 in the same cycle as read_valid if any byte mismatches, otherwise 0. The clear sweep writes correct parity for zero data. Reset value of parity_err is 0.
DM_PARITY_EN undefined: no parity storage, and the ports parity_err and perr_inject do not exist.

Decomposition:
- Package dm_pkg: FSM enum {DM_CLEAR, DM_READY}; function byte_merge(old, new, be); function byte_parity(word) returning a DATA_W/8 vector.
- One sub-module, dm_clear_ctrl: holds the FSM and the clear index counter, and outputs busy, the clear write enable and the clear index.

Test Plan:
- Release reset, hold MemRead=1 with read_address=3 -> busy=1 for exactly 64 cycles and read_valid=0 throughout; after that, read returns 0x00000000 with read_valid=1.
- Write address 3 with 0xFFFFFFFF and byte_en=4'hF, then read 3 -> MemData_out=0xFFFFFFFF one cycle after MemRead.
- Write address 3 with 0x12345678 and byte_en=4'b0101 over prior 0xFFFFFFFF -> read returns 0xFF34FF78.
- Same-cycle write of 0xA5A5A5A5 and read, both to address 10 -> next cycle MemData_out=0xA5A5A5A5.
- Write to address 64, then read address 100 -> memory unchanged, addr_err pulses on both, and the read returns 0 with read_valid=1.
- Drive reset low at clear index 30, then release -> busy stays high for a full 64 more cycles; with DM_PARITY_EN, a write using perr_inject=1 followed by a read of that word gives parity_err=1.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and helpers for data_memory_param.
//   dm_state_e  : clear/ready state of the post-reset zeroing sweep
//   byte_merge  : overlay byte-enabled lanes of a new word onto an old word
//   byte_parity : per-byte even-parity vector of a word
// The helpers work on DM_MAX_W-bit words. Callers zero-extend narrower words
// and truncate the result. DATA_W must not exceed DM_MAX_W.
package dm_pkg;

  localparam int DM_MAX_W = 512;
  localparam int DM_MAX_B = DM_MAX_W / 8;

  typedef enum logic [0:0] {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_e;

  function automatic logic [DM_MAX_W-1:0] byte_merge(
    input logic [DM_MAX_W-1:0] old_w,
    input logic [DM_MAX_W-1:0] new_w,
    input logic [DM_MAX_B-1:0] be
  );
    logic [DM_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < DM_MAX_B; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Even parity: the stored bit makes byte plus bit hold an even count of ones.
  function automatic logic [DM_MAX_B-1:0] byte_parity(input logic [DM_MAX_W-1:0] w);
    logic [DM_MAX_B-1:0] p;
    for (int i = 0; i < DM_MAX_B; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction

endpackage

// File: rtl/dm_clear_ctrl.sv
// Post-reset clear sequencer for data_memory_param.
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset
//   o_busy     high while the zeroing sweep runs
//   o_clr_we   write enable for the zero write of the current index
//   o_clr_idx  word index being cleared this cycle
// The sweep visits indices 0..DEPTH-1, one per cycle. Asserting reset mid-sweep
// restarts it from index 0.
module dm_clear_ctrl
  import dm_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_busy,
  output logic             o_clr_we,
  output logic [IDX_W-1:0] o_clr_idx
);

  dm_state_e        r_state;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= DM_CLEAR;
      r_idx   <= '0;
    end else if (r_state == DM_CLEAR) begin
      if (r_idx == IDX_W'(DEPTH - 1)) begin
        r_state <= DM_READY;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_busy    = (r_state == DM_CLEAR);
  assign o_clr_we  = (r_state == DM_CLEAR);
  assign o_clr_idx = r_idx;

endmodule

// File: rtl/data_memory_param.sv
// Parametrised data memory for the MEM stage. It has one write port and one
// read port, with byte strobes and a 1-cycle registered read. A write and a
// read to the same address in one cycle forward the post-write word. Requests
// to addresses >= DEPTH are flagged, and a zeroing sweep runs after reset.
// Ports:
//   clk, reset (sync, active-low)
//   MemWrite, write_address, Write_data, byte_en   write port
//   MemRead, read_address                          read request
//   MemData_out, read_valid                        registered read result
//   busy                                           clear sweep in progress
//   addr_err                                       pulse for previous-cycle out-of-range request
//   parity_err, perr_inject                        present only when DM_PARITY_EN is defined
// Build option: `define DM_PARITY_EN adds per-byte even parity storage and checking.
module data_memory_param
  import dm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [ADDR_W-1:0]   write_address,
  input  logic [ADDR_W-1:0]   read_address,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   MemData_out,
  output logic                read_valid,
  output logic                busy,
  output logic                addr_err
`ifdef DM_PARITY_EN
  ,
  output logic                parity_err,
  input  logic                perr_inject
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [IDX_W-1:0]  w_clr_idx;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_wr_go;
  logic              w_fwd;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_word;

  logic [DATA_W-1:0] r_rdata_p1;
  logic              vld_p1;
  logic              r_aerr_p1;

  dm_clear_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_clear (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_idx (w_clr_idx)
  );

  // Range checks use the full port width, so high address bits never alias.
  always_comb begin
    w_wr_ok   = (64'(write_address) < 64'(DEPTH));
    w_rd_ok   = (64'(read_address)  < 64'(DEPTH));
    w_wr_idx  = write_address[IDX_W-1:0];
    w_rd_idx  = read_address[IDX_W-1:0];
    w_wr_go   = reset && !w_busy && MemWrite && w_wr_ok;
    w_fwd     = w_wr_go && MemRead && (write_address == read_address);
    w_merged  = DATA_W'(byte_merge(DM_MAX_W'(r_mem[w_wr_idx]), DM_MAX_W'(Write_data),
                                   DM_MAX_B'(byte_en)));
    w_rd_word = w_fwd ? w_merged : r_mem[w_rd_idx];
  end

  // Storage: the clear sweep takes priority, and user writes only land when ready.
  always_ff @(posedge clk) begin
    if (reset && w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_go) begin
      r_mem[w_wr_idx] <= w_merged;
    end
  end

  // ---- stage p1: registered read result and error pulse ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata_p1 <= '0;
      vld_p1     <= 1'b0;
      r_aerr_p1  <= 1'b0;
    end else if (w_busy) begin
      r_rdata_p1 <= '0;
      vld_p1     <= 1'b0;
      r_aerr_p1  <= 1'b0;
    end else begin
      vld_p1    <= MemRead;
      r_aerr_p1 <= (MemWrite && !w_wr_ok) || (MemRead && !w_rd_ok);
      if (MemRead) r_rdata_p1 <= w_rd_ok ? w_rd_word : '0;
    end
  end

  assign MemData_out = r_rdata_p1;
  assign read_valid  = vld_p1;
  assign busy        = w_busy;
  assign addr_err    = r_aerr_p1;

`ifdef DM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_par_new;
  logic [NB-1:0] w_par_merged;
  logic [NB-1:0] w_rd_par;
  logic          r_perr_p1;

  // Enabled lanes take the fresh parity, optionally inverted for fault injection.
  always_comb begin
    w_par_new    = NB'(byte_parity(DM_MAX_W'(Write_data))) ^ {NB{perr_inject}};
    w_par_merged = r_par[w_wr_idx];
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) w_par_merged[i] = w_par_new[i];
    end
    w_rd_par = w_fwd ? w_par_merged : r_par[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (reset && w_clr_we) begin
      r_par[w_clr_idx] <= NB'(byte_parity('0));
    end else if (w_wr_go) begin
      r_par[w_wr_idx] <= w_par_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || w_busy) begin
      r_perr_p1 <= 1'b0;
    end else begin
      r_perr_p1 <= MemRead && w_rd_ok &&
                   (|(NB'(byte_parity(DM_MAX_W'(w_rd_word))) ^ w_rd_par));
    end
  end

  assign parity_err = r_perr_p1;
`endif

endmodule
